// File: rtl/mem_requester_pkg.sv
// Shared memory geometry for the requester and its dual-port RAM.
// The width macros are defined here when no project-wide definition exists.
`ifndef MEMORY_ADDR_WIDTH
`define MEMORY_ADDR_WIDTH 11
`endif
`ifndef MEMORY_DATA_WIDTH
`define MEMORY_DATA_WIDTH 16
`endif

package mem_requester_pkg;
  localparam int MEM_ADDR_WIDTH = `MEMORY_ADDR_WIDTH;
  localparam int MEM_DATA_WIDTH = `MEMORY_DATA_WIDTH;
  localparam int RAM_DEPTH      = 1 << MEM_ADDR_WIDTH;
endpackage

// File: rtl/mem_requester.sv
// Single-request front end for a dual-port RAM: either one write or one paired read
// per transaction. The read response is held until the client consumes it.
module mem_requester
  import mem_requester_pkg::*;
#(
  parameter int ADDR_WIDTH = MEM_ADDR_WIDTH,
  parameter int DATA_WIDTH = MEM_DATA_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr1,
  input  logic [ADDR_WIDTH-1:0] req_addr2,
  input  logic [DATA_WIDTH-1:0] req_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_q1,
  output logic [DATA_WIDTH-1:0] rsp_q2,
  output logic [ADDR_WIDTH-1:0] ram_address1,
  output logic [ADDR_WIDTH-1:0] ram_address2,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic                  ram_wren,
  input  logic [DATA_WIDTH-1:0] ram_q1,
  input  logic [DATA_WIDTH-1:0] ram_q2,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } state_t;

  state_t state, state_nxt;
  logic   accept;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready;
  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // ram_wren doubles as the "this is a write" flag while in ISSUE
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ISSUE;
      ISSUE:   state_nxt = ram_wren ? IDLE : CAPTURE;
      CAPTURE: state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // RAM-side registers only move on accept, so they hold outside ISSUE;
  // wren self-clears after its single ISSUE cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ram_address1 <= '0;
      ram_address2 <= '0;
      ram_data     <= '0;
      ram_wren     <= 1'b0;
    end else if (accept) begin
      ram_address1 <= req_addr1;
      ram_address2 <= req_addr2;
      ram_data     <= req_data;
      ram_wren     <= req_write;
    end else begin
      ram_wren     <= 1'b0;
    end
  end

  // RAM output is valid one edge after ISSUE, i.e. during CAPTURE
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rsp_q1 <= '0;
      rsp_q2 <= '0;
    end else if (state == CAPTURE) begin
      rsp_q1 <= ram_q1;
      rsp_q2 <= ram_q2;
    end
  end

endmodule

// File: tb/tb_mem_requester.sv
// Bench for mem_requester: behavioural dual-port RAM, array reference model of memory
// contents, directed scenarios plus randomized traffic.
module tb_mem_requester;
  import mem_requester_pkg::*;

  localparam int AW = MEM_ADDR_WIDTH;
  localparam int DW = MEM_DATA_WIDTH;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0, req_ready, req_write = 1'b0;
  logic [AW-1:0] req_addr1 = '0, req_addr2 = '0;
  logic [DW-1:0] req_data = '0;
  logic          rsp_valid, rsp_ready = 1'b0;
  logic [DW-1:0] rsp_q1, rsp_q2;
  logic [AW-1:0] ram_address1, ram_address2;
  logic [DW-1:0] ram_data;
  logic          ram_wren;
  logic [DW-1:0] ram_q1 = '0, ram_q2 = '0;
  logic          busy;

  int checks = 0;
  int errors = 0;
  int wren_cnt = 0;

  logic [DW-1:0] mem     [RAM_DEPTH];
  logic [DW-1:0] ref_mem [RAM_DEPTH];

  mem_requester #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr1(req_addr1), .req_addr2(req_addr2), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_q1(rsp_q1), .rsp_q2(rsp_q2),
    .ram_address1(ram_address1), .ram_address2(ram_address2), .ram_data(ram_data),
    .ram_wren(ram_wren), .ram_q1(ram_q1), .ram_q2(ram_q2), .busy(busy)
  );

  always #5 clock = ~clock;

  // dual-port RAM with registered read, write through port 1
  always @(posedge clock) begin
    if (ram_wren === 1'b1) begin
      mem[ram_address1] <= ram_data;
      wren_cnt <= wren_cnt + 1;
    end
    ram_q1 <= mem[ram_address1];
    ram_q2 <= mem[ram_address2];
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (req_ready !== 1'b1 && n < 50) begin tick(); n++; end
    checks++;
    if (n >= 50) begin errors++; $display("FAIL wait_ready: req_ready=%b after %0d cycles, want 1", req_ready, n); end
  endtask

  task automatic junk_inputs();
    req_valid = 1'b1;
    req_write = 1'($urandom);
    req_addr1 = AW'($urandom);
    req_addr2 = AW'($urandom);
    req_data  = DW'($urandom);
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    int start;
    wait_ready();
    start = wren_cnt;
    req_valid = 1'b1; req_write = 1'b1; req_addr1 = a; req_addr2 = AW'($urandom); req_data = d;
    tick();
    req_valid = 1'b0;
    checks++;
    if (ram_wren !== 1'b1 || ram_address1 !== a || ram_data !== d) begin
      errors++;
      $display("FAIL write_issue: wren=%b addr=%h data=%h, want 1 %h %h", ram_wren, ram_address1, ram_data, a, d);
    end
    tick();
    checks++;
    if (ram_wren !== 1'b0 || busy !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL write_done: wren=%b busy=%b rsp_valid=%b, want 0 0 0", ram_wren, busy, rsp_valid);
    end
    checks++;
    if (wren_cnt !== start + 1) begin
      errors++;
      $display("FAIL write_pulse: wren cycles=%0d, want 1", wren_cnt - start);
    end
    ref_mem[a] = d;
  endtask

  // read pair; stall = cycles with rsp_ready low after rsp_valid rises
  task automatic do_read(input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                         input int stall, input bit junk);
    logic [DW-1:0] e1, e2;
    int start;
    wait_ready();
    start = wren_cnt;
    e1 = ref_mem[a1];
    e2 = ref_mem[a2];
    req_valid = 1'b1; req_write = 1'b0; req_addr1 = a1; req_addr2 = a2; req_data = DW'($urandom);
    tick();                                   // accept edge (edge 1)
    if (junk) junk_inputs(); else req_valid = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b1 || req_ready !== 1'b0) begin
      errors++;
      $display("FAIL read_edge1: rsp_valid=%b busy=%b req_ready=%b, want 0 1 0", rsp_valid, busy, req_ready);
    end
    tick();                                   // edge 2
    if (junk) junk_inputs();
    checks++;
    if (rsp_valid !== 1'b0 || ram_wren !== 1'b0) begin
      errors++;
      $display("FAIL read_edge2: rsp_valid=%b wren=%b, want 0 0", rsp_valid, ram_wren);
    end
    tick();                                   // edge 3: response visible
    checks++;
    if (rsp_valid !== 1'b1 || rsp_q1 !== e1 || rsp_q2 !== e2) begin
      errors++;
      $display("FAIL read_resp: valid=%b q1=%h q2=%h, want 1 %h %h (a1=%h a2=%h)", rsp_valid, rsp_q1, rsp_q2, e1, e2, a1, a2);
    end
    for (int i = 0; i < stall; i++) begin
      if (junk) junk_inputs();
      tick();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_q1 !== e1 || rsp_q2 !== e2 || req_ready !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL read_stall%0d: valid=%b q1=%h q2=%h ready=%b busy=%b, want 1 %h %h 0 1", i, rsp_valid, rsp_q1, rsp_q2, req_ready, busy, e1, e2);
      end
    end
    rsp_ready = 1'b1;
    if (junk) junk_inputs();
    tick();
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    checks++;
    if (busy !== 1'b0 || req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_q1 !== e1 || rsp_q2 !== e2) begin
      errors++;
      $display("FAIL read_consume: busy=%b ready=%b valid=%b q1=%h q2=%h, want 0 1 0 %h %h", busy, req_ready, rsp_valid, rsp_q1, rsp_q2, e1, e2);
    end
    checks++;
    if (wren_cnt !== start || ram_address1 !== a1 || ram_address2 !== a2) begin
      errors++;
      $display("FAIL read_side_effects: wren cycles=%0d addr1=%h addr2=%h, want 0 %h %h", wren_cnt - start, ram_address1, ram_address2, a1, a2);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req_valid = 1'b1; req_write = 1'b1; req_addr1 = 'h3; req_data = 'h5555;
    tick(); tick();
    checks++;
    if (rsp_valid !== 1'b0 || ram_wren !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ctrl: valid=%b wren=%b busy=%b ready=%b, want 0 0 0 1", rsp_valid, ram_wren, busy, req_ready);
    end
    checks++;
    if (rsp_q1 !== '0 || rsp_q2 !== '0 || ram_address1 !== '0 || ram_address2 !== '0 || ram_data !== '0) begin
      errors++;
      $display("FAIL reset_data: q1=%h q2=%h a1=%h a2=%h d=%h, want all 0", rsp_q1, rsp_q2, ram_address1, ram_address2, ram_data);
    end
    req_valid = 1'b0;
    reset = 1'b0;
    tick();
    checks++;
    if (wren_cnt !== 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_accept: wren cycles=%0d busy=%b, want 0 0", wren_cnt, busy);
    end
  endtask

  task automatic test_basic();
    do_write('h006, 'hABCD);
    do_write('h005, 'h1234);
    do_read('h005, 'h006, 0, 0);
  endtask

  task automatic test_boundary();
    int start;
    start = wren_cnt;
    do_write('h7FF, DW'($urandom));
    do_read('h7FF, 'h000, 0, 0);
    checks++;
    if (wren_cnt !== start + 1) begin
      errors++;
      $display("FAIL boundary_wren_total: %0d cycles, want 1", wren_cnt - start);
    end
  endtask

  task automatic test_stall();
    do_write('h040, DW'($urandom));
    do_read('h040, 'h006, 10, 0);
  endtask

  task automatic test_reset_abort();
    int start;
    logic [DW-1:0] d;
    // reset during CAPTURE of a read
    wait_ready();
    req_valid = 1'b1; req_write = 1'b0; req_addr1 = 'h005; req_addr2 = 'h006;
    tick();
    req_valid = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || ram_wren !== 1'b0 || rsp_q1 !== '0 || rsp_q2 !== '0 ||
        ram_address1 !== '0 || ram_address2 !== '0 || ram_data !== '0) begin
      errors++;
      $display("FAIL abort_read_outputs: valid=%b busy=%b wren=%b q1=%h q2=%h a1=%h a2=%h d=%h, want all 0",
               rsp_valid, busy, ram_wren, rsp_q1, rsp_q2, ram_address1, ram_address2, ram_data);
    end
    tick(); tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (rsp_valid !== 1'b0) begin errors++; $display("FAIL abort_read_no_rsp: rsp_valid=%b cycle %0d, want 0", rsp_valid, i); end
    end
    // reset during ISSUE of a write: the write must not land
    start = wren_cnt;
    d = ~ref_mem['h020];
    wait_ready();
    req_valid = 1'b1; req_write = 1'b1; req_addr1 = 'h020; req_data = d;
    tick();
    req_valid = 1'b0;
    reset = 1'b1;
    #1;
    checks++;
    if (ram_wren !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_write_outputs: wren=%b busy=%b, want 0 0", ram_wren, busy);
    end
    tick(); tick();
    reset = 1'b0;
    tick();
    checks++;
    if (wren_cnt !== start) begin
      errors++;
      $display("FAIL abort_write_pulse: wren cycles=%0d, want 0", wren_cnt - start);
    end
    do_read('h020, 'h005, 1, 0);
  endtask

  task automatic test_toggle_busy();
    do_write('h033, DW'($urandom));
    do_write('h034, DW'($urandom));
    do_read('h033, 'h034, 6, 1);
    do_read('h033, 'h034, 0, 0);
  endtask

  task automatic test_back_to_back();
    do_write('h010, 'h00FF);
    do_read('h010, 'h011, 0, 0);
  endtask

  task automatic test_random();
    logic [AW-1:0] pool [5];
    logic [AW-1:0] a1, a2;
    pool[0] = 'h000; pool[1] = 'h7FF; pool[2] = 'h010; pool[3] = 'h011; pool[4] = 'h123;
    for (int i = 0; i < 40; i++) begin
      a1 = pool[$urandom_range(0, 4)];
      a2 = pool[$urandom_range(0, 4)];
      if ($urandom_range(0, 1) == 1) do_write(a1, DW'($urandom));
      else do_read(a1, a2, $urandom_range(0, 3), 1'($urandom));
      repeat ($urandom_range(0, 2)) tick();
    end
  endtask

  initial begin
    for (int i = 0; i < RAM_DEPTH; i++) begin mem[i] = '0; ref_mem[i] = '0; end
    test_reset();
    test_basic();
    test_boundary();
    test_stall();
    test_reset_abort();
    test_toggle_busy();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
